ifu_prefetch: RTL and testbench
===============================

// Module: ifu_prefetch
// PURPOSE
//  Parametrised instruction fetch unit with prefetch buffer. Owns the fetch PC.
//  Issues sequential SimpleBus reads with a valid/ready request and a variable-latency response.
//  Queues fetched words in a DEPTH-entry FIFO; IDU drains it over a valid/ready handshake.
//  Supports redirect (branch/trap from WBU) with flush, and bus error reporting. Sits between WBU/IDU and memory.
// PARAMETERS
//  XLEN      32            instruction/data width
//  ADDR_W    32            address width
//  DEPTH     2             prefetch FIFO entries (power of 2, >=1)
//  RESET_PC  32'h80000000  fetch PC after reset
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       synchronous reset, active-high
//  redirect_valid  in   1       load new fetch PC, flush buffer
//  redirect_pc     in   ADDR_W  target PC; bits[1:0] are ignored and forced to 0
//  mem_req_valid   out  1       read request valid
//  mem_req_ready   in   1       memory accepts request
//  mem_req_addr    out  ADDR_W  read address (word aligned)
//  mem_resp_valid  in   1       read data valid (1 cycle pulse per request)
//  mem_resp_data   in   XLEN    read data
//  mem_resp_err    in   1       access fault for this response
//  inst_valid      out  1       FIFO head valid to IDU
//  inst_ready      in   1       IDU consumes head
//  inst            out  XLEN    head instruction
//  inst_pc         out  ADDR_W  PC of head instruction
//  inst_err        out  1       head carries access fault
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, FIFO empty.
//   mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0.
//   mem_req_addr=RESET_PC. rst mid-transfer discards the outstanding response.
//  At most one outstanding request. space = (fifo_count < DEPTH); an outstanding request reserves one slot.
//  States:
//   IDLE  mem_req_valid = space & ~redirect_valid; mem_req_addr = fetch_pc.
//         Handshake (valid&ready) -> WAIT, fetch_pc += 4 (wraps mod 2^ADDR_W).
//   WAIT  on mem_resp_valid: push {data,fetch_pc-4,err}.
//         err=0 -> IDLE; err=1 -> HALT.
//   DROP  stale request outstanding. On mem_resp_valid: discard the response -> IDLE.
//   HALT  no requests. Leaves only via redirect.
//  Request rules: once asserted, mem_req_valid and addr stay stable until ready,
//   except a redirect withdraws them the same cycle.
//  Redirect (cycle N), highest priority:
//   FIFO flushed (a pop in cycle N is void); fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b0}.
//   From IDLE/HALT -> IDLE.
//   From WAIT -> DROP, unless mem_resp_valid in N, in which case the response is discarded -> IDLE.
//   From DROP -> DROP, unless mem_resp_valid in N -> IDLE.
//   A mem_req_ready seen while redirect_valid is high is not a handshake, because valid is 0.
//   Earliest new request: N+1 with addr=redirect_pc.
//  Latency: response at cycle M -> inst_valid=1 at M+1 (FIFO registered).
//   With a 0-wait memory (ready=1, resp the cycle after the request), throughput is 1 inst per 2 cycles.
//  FIFO: push and pop in the same cycle are both allowed, count is unchanged.
//   Head outputs hold while inst_valid & ~inst_ready.
//   Never overflows, because of the slot reservation. inst=0 when empty.
//  mem_resp_valid in IDLE/HALT is a protocol error: ignored, with a simulation $error.
// STRUCTURE
//  ifu_pkg: state encoding (IDLE/WAIT/DROP/HALT, 2 bits), INST_BYTES=4, FIFO entry width macro.
//  Sub-module ifu_fifo: generic sync FIFO (WIDTH, DEPTH; push/pop/flush/count/head).
//   The FSM, fetch PC and bus control live in ifu_prefetch.
// TESTING
//  1. Reset, mem ready=1, resp next cycle, inst_ready=1.
//     -> addrs 0x80000000,0x80000004,...; inst_pc matches; inst at resp+1.
//  2. inst_ready=0, DEPTH=2.
//     -> exactly 2 requests issued, then mem_req_valid=0 until inst_ready returns.
//  3. mem_req_ready=0 for 3 cycles.
//     -> addr stable and valid held; single handshake on the 4th cycle.
//  4. Redirect to 0x80000100 while in WAIT; stale resp 0xDEADBEEF arrives 2 cycles later.
//     -> stale data discarded; FIFO empty; next request addr=0x80000100.
//  5. Redirect in the same cycle as mem_resp_valid.
//     -> data dropped; request to the new PC on the next cycle; no DROP state.
//  6. mem_resp_err=1 at 0x80000008.
//     -> inst_err=1, inst_pc=0x80000008; no further requests until redirect; then resumes.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding
// and the layout of a prefetch buffer entry.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } ifu_state_e;

  localparam int INST_BYTES = 4;

  // Entry layout, MSB first: {inst, pc, err}
  function automatic int fifo_entry_w(input int xlen, input int addr_w);
    return xlen + addr_w + 1;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush; head reads as zero when empty.
module ifu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: it is only visible through a valid count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, issues one sequential bus read
// at a time and buffers returned words for the decoder.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               ADDR_W   = 32,
  parameter int               DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  input  logic              mem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  localparam int EW    = fifo_entry_w(XLEN, ADDR_W);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ifu_state_e        state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic              space, req_hs, push, pop;
  logic [ADDR_W-1:0] req_pc, redir_target;

  // Requests only leave IDLE, so no request is ever outstanding while space
  // is evaluated; the single outstanding request implicitly owns one slot.
  assign space         = (fifo_count < CNT_W'(DEPTH));
  assign mem_req_valid = ~rst & (state_q == ST_IDLE) & space & ~redirect_valid;
  assign mem_req_addr  = fetch_pc_q;
  assign req_hs        = mem_req_valid & mem_req_ready;

  assign req_pc       = fetch_pc_q - ADDR_W'(INST_BYTES);
  assign redir_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign push = mem_resp_valid & (state_q == ST_WAIT) & ~redirect_valid;
  assign pop  = inst_valid & inst_ready & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redir_target;
      case (state_q)
        ST_WAIT, ST_DROP: state_q <= mem_resp_valid ? ST_IDLE : ST_DROP;
        default:          state_q <= ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: if (req_hs) begin
          state_q    <= ST_WAIT;
          fetch_pc_q <= fetch_pc_q + ADDR_W'(INST_BYTES);
        end
        ST_WAIT: if (mem_resp_valid) state_q <= mem_resp_err ? ST_HALT : ST_IDLE;
        ST_DROP: if (mem_resp_valid) state_q <= ST_IDLE;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_resp_valid)
      assert (state_q == ST_WAIT || state_q == ST_DROP)
        else $error("ifu_prefetch: mem_resp_valid with no outstanding request");
  end

  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mem_resp_data, req_pc, mem_resp_err}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign inst_valid = ~fifo_empty;
  assign {inst, inst_pc, inst_err} = fifo_head;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a bench-side memory model answers
// requests, expected entries are queued on response and checked on pop.
module tb_ifu_prefetch;

  logic        clk, rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_err;

  ifu_prefetch #(.XLEN(32), .ADDR_W(32), .DEPTH(2), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0;
  int          n_req = 0, lat = 1, out_cnt = 0;
  logic [31:0] exp_addr, out_addr, err_addr, obs_addr, last_pc;
  logic        out_pend, out_stale, obs_valid, last_err;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_1234;
  endfunction

  // One clock: check DUT outputs, update scoreboard, then drive memory response.
  task automatic step();
    exp_t e;
    logic ev, hs;
    #1;
    obs_valid = mem_req_valid;
    obs_addr  = mem_req_addr;
    ev = (q.size() != 0);
    checks++;
    if (inst_valid !== ev || (!ev && (inst !== 32'h0 || inst_pc !== 32'h0 || inst_err !== 1'b0))) begin
      errors++;
      $display("FAIL head_state: inst_valid=%b inst=%h pc=%h err=%b, expected valid=%b (zero head when empty)",
               inst_valid, inst, inst_pc, inst_err, ev);
    end
    hs = mem_req_valid && mem_req_ready;
    if (hs) begin
      checks++;
      if (mem_req_addr !== exp_addr) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", mem_req_addr, exp_addr);
      end
      out_pend = 1'b1; out_addr = exp_addr; out_cnt = lat; out_stale = 1'b0;
      exp_addr = exp_addr + 32'd4;
      n_req++;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: inst=%h pc=%h, expected no entry", inst, inst_pc);
      end else begin
        e = q.pop_front();
        if (inst !== e.data || inst_pc !== e.pc || inst_err !== e.err) begin
          errors++;
          $display("FAIL pop_data: got inst=%h pc=%h err=%b expected inst=%h pc=%h err=%b",
                   inst, inst_pc, inst_err, e.data, e.pc, e.err);
        end
        last_pc = inst_pc; last_err = inst_err;
      end
    end
    if (mem_resp_valid && out_pend && !out_stale && !redirect_valid)
      q.push_back('{data: memf(out_addr), pc: out_addr, err: (out_addr == err_addr)});
    if (redirect_valid) begin
      q.delete();
      exp_addr = {redirect_pc[31:2], 2'b00};
      if (out_pend) out_stale = 1'b1;
    end
    @(posedge clk); #1;
    if (mem_resp_valid) out_pend = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0; mem_resp_err = 1'b0;
    if (out_pend) begin
      out_cnt--;
      if (out_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = out_stale ? 32'hDEAD_BEEF : memf(out_addr);
        mem_resp_err   = !out_stale && (out_addr == err_addr);
      end
    end
  endtask

  task automatic drain();
    mem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_req: valid=%b addr=%h expected 0 / 80000000", mem_req_valid, mem_req_addr);
    end
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_head: valid=%b inst=%h pc=%h err=%b expected all 0", inst_valid, inst, inst_pc, inst_err);
    end
    rst = 1'b0;
    exp_addr = 32'h8000_0000;
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_first_req: valid=%b addr=%h expected 1 / 80000000", obs_valid, obs_addr);
    end
  endtask

  task automatic test_sequential();
    int n0;
    mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    n0 = n_req;
    repeat (20) step();
    checks++;
    if (n_req - n0 != 10) begin
      errors++;
      $display("FAIL seq_throughput: %0d requests in 20 cycles expected 10", n_req - n0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n0;
    inst_ready = 1'b0; mem_req_ready = 1'b1; lat = 1;
    n0 = n_req;
    repeat (12) step();
    checks++;
    if (n_req - n0 != 2 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure: %0d requests, req_valid=%b expected 2 / 0", n_req - n0, obs_valid);
    end
    drain();
  endtask

  task automatic test_req_stall();
    int n0;
    logic [31:0] a0;
    a0 = exp_addr; n0 = n_req;
    mem_req_ready = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_valid !== 1'b1 || obs_addr !== a0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid=%b addr=%h expected 1 / %h", i, obs_valid, obs_addr, a0);
      end
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checks++;
    if (n_req - n0 != 1) begin
      errors++;
      $display("FAIL stall_handshake: %0d handshakes expected 1", n_req - n0);
    end
    drain();
  endtask

  task automatic test_redirect_wait();
    mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 3;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_no_req: cycle %0d req_valid=%b expected 0", i, obs_valid);
      end
    end
    lat = 1;
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL redirect_wait_req: valid=%b addr=%h expected 1 / 80000100", obs_valid, obs_addr);
    end
    drain();
  endtask

  task automatic test_redirect_same();
    mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_addr !== 32'h8000_0200) begin
      errors++;
      $display("FAIL redirect_same_req: valid=%b addr=%h expected 1 / 80000200", obs_valid, obs_addr);
    end
    drain();
  endtask

  task automatic test_bus_error();
    int n0;
    err_addr = 32'h8000_0008;
    mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    step();
    redirect_valid = 1'b0;
    n0 = n_req;
    repeat (10) step();
    checks++;
    if (n_req - n0 != 3 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_halt: %0d requests, req_valid=%b expected 3 / 0", n_req - n0, obs_valid);
    end
    checks++;
    if (last_pc !== 32'h8000_0008 || last_err !== 1'b1) begin
      errors++;
      $display("FAIL err_report: last pc=%h err=%b expected 80000008 / 1", last_pc, last_err);
    end
    err_addr = 32'h0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    step();
    redirect_valid = 1'b0;
    n0 = n_req;
    repeat (6) step();
    checks++;
    if (n_req - n0 != 3) begin
      errors++;
      $display("FAIL err_resume: %0d requests after redirect expected 3", n_req - n0);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0; mem_resp_err = 1'b0;
    inst_ready = 1'b0;
    exp_addr = 32'h8000_0000; out_addr = 32'h0; err_addr = 32'h0;
    obs_addr = 32'h0; last_pc = 32'h0;
    out_pend = 1'b0; out_stale = 1'b0; obs_valid = 1'b0; last_err = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_req_stall();
    test_redirect_wait();
    test_redirect_same();
    test_bus_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
